// File: rtl/ren_conv_pkg.sv
// ren_conv_pkg: shared constants, register map and FSM encoding for the
// ren_conv convolution accelerator.
package ren_conv_pkg;

   // Datapath geometry: three unsigned byte lanes per RAM word.
   localparam int LANES  = 3;
   localparam int LANE_W = 8;
   localparam int ACC_W  = 24;

   // Bus regions selected by address bits [9:8].
   localparam logic [1:0] REGION_REG  = 2'd0;
   localparam logic [1:0] REGION_IMG  = 2'd1;
   localparam logic [1:0] REGION_KERN = 2'd2;
   localparam logic [1:0] REGION_RSLT = 2'd3;

   // Register indices inside the register region.
   localparam logic [7:0] REG_CTRL = 8'd0;
   localparam logic [7:0] REG_CFG  = 8'd1;
   localparam logic [7:0] REG_OUT  = 8'd2;

   // Reg0 (control/status) bit positions.
   localparam int CTRL_DONE_BIT  = 0;
   localparam int CTRL_BUSY_BIT  = 1;
   localparam int CTRL_START_BIT = 2;

   // Reg1 (geometry) field positions.
   localparam int CFG_KCOLS_LSB  = 0;
   localparam int CFG_COLS_LSB   = 8;
   localparam int CFG_KERNS_LSB  = 16;
   localparam int CFG_STRIDE_LSB = 24;

   // Reg2 (output control) field positions.
   localparam int OUT_RCOLS_LSB = 0;
   localparam int OUT_SHIFT_LSB = 8;
   localparam int OUT_MODE_BIT  = 16;
   localparam int OUT_POOL_BIT  = 17;
   localparam int OUT_MASK_LSB  = 18;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WR    = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Scale an accumulator down by a right shift and clamp to one byte.
   function automatic logic [7:0] sat_shift(input logic [ACC_W-1:0] acc,
                                            input logic [3:0] sh);
      logic [ACC_W-1:0] v;
      v = acc >> sh;
      if (v > ACC_W'(8'd255)) begin
         return 8'hFF;
      end else begin
         return v[7:0];
      end
   endfunction

endpackage

// File: rtl/ren_conv_mac.sv
// ren_conv_mac: three-lane 8x8 unsigned multiply-accumulate. Lanes whose
// mask bit is clear contribute nothing; clear has priority over enable.
module ren_conv_mac
   import ren_conv_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic [LANES-1:0]        mask_i,
   input  logic [LANES*LANE_W-1:0] img_i,
   input  logic [LANES*LANE_W-1:0] kern_i,
   output logic [ACC_W-1:0]        acc_o
);

   localparam int SUM_W = 2 * LANE_W + 2;

   logic [SUM_W-1:0] sum_s;
   logic [ACC_W-1:0] acc_q;

   // Sum of the enabled lane products for the current kernel column.
   always_comb begin
      sum_s = '0;
      for (int l = 0; l < LANES; l++) begin
         if (mask_i[l]) begin
            sum_s = sum_s + SUM_W'(img_i[l*LANE_W +: LANE_W]) * SUM_W'(kern_i[l*LANE_W +: LANE_W]);
         end else begin
            sum_s = sum_s;
         end
      end
   end

   // Accumulator register: cleared at the start of each position.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q + ACC_W'(sum_s);
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/ren_conv_top.sv
// ren_conv_top: Wishbone-slave convolution accelerator. Holds the bus
// interface, configuration registers, image/kernel/result RAMs and the
// sequencing FSM; the arithmetic lives in ren_conv_mac.
// Optional feature macro: REN_CONV_MAX_POOL_EN enables 2:1 max pooling
// (reg2 bit 17); without it every value is written unpooled.
module ren_conv_top
   import ren_conv_pkg::*;
#(
   parameter int KERN_COL_WIDTH  = 3,
   parameter int COL_WIDTH       = 8,
   parameter int KERN_CNT_WIDTH  = 3,
   parameter int IMG_ADDR_WIDTH  = 6,
   parameter int RSLT_ADDR_WIDTH = 6
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o
);

   localparam int KA_W       = KERN_CNT_WIDTH + KERN_COL_WIDTH;
   localparam int IMG_DEPTH  = 1 << IMG_ADDR_WIDTH;
   localparam int KERN_DEPTH = 1 << KA_W;
   localparam int RSLT_DEPTH = 1 << RSLT_ADDR_WIDTH;
   localparam int BASE_W     = COL_WIDTH + 2;
   localparam int POS_W      = COL_WIDTH + 1;
   localparam int DW         = LANES * LANE_W;

   // Bus interface
   logic        ack_q;
   logic [31:0] dat_o_q;
   logic        bus_req_s, bus_wr_s, hi_zero_s;
   logic [1:0]  region_s;
   logic [7:0]  index_s;
   logic        reg_hit_s, img_hit_s, kern_hit_s, rslt_hit_s;
   logic        start_s, cfg1_we_s, cfg2_we_s, img_we_s, kern_we_s, host_rs_we_s;
   logic [31:0] rd_data_s, ctrl_rd_s, cfg1_rd_s, cfg2_rd_s;

   // Configuration
   logic [KERN_COL_WIDTH-1:0] kern_cols_q;
   logic [COL_WIDTH-1:0]      cols_q;
   logic [KERN_CNT_WIDTH-1:0] kerns_q;
   logic [7:0]                stride_q;
   logic [7:0]                rcols_q;
   logic [3:0]                shift_q;
   logic                      mode_q;
   logic [LANES-1:0]          mask_q;
   logic                      pool_en_s;
`ifdef REN_CONV_MAX_POOL_EN
   logic                      pool_en_q;
   logic [7:0]                pool_v_q;
`endif

   // Memories and engine datapath
   logic [31:0] img_mem  [IMG_DEPTH];
   logic [31:0] kern_mem [KERN_DEPTH];
   logic [31:0] rslt_mem [RSLT_DEPTH];
   logic [DW-1:0] img_rd_q, kern_rd_q;
   logic          rd_vld_q;
   logic [ACC_W-1:0] acc_s;

   // Sequencer
   state_e                    state_q, state_d;
   logic [KERN_COL_WIDTH-1:0] c_q, c_d;
   logic [KERN_CNT_WIDTH-1:0] k_q, k_d;
   logic [BASE_W-1:0]         base_q, base_d;
   logic [POS_W-1:0]          p_q, p_d;
   logic                      done_q, done_d;
   logic                      busy_s, mac_clr_s, first_ok_s, last_pos_s, eng_we_s;
   logic [7:0]                stride_eff_s, v_s, wr_val_s;
   logic [POS_W-1:0]          rslt_idx_s;
   logic [IMG_ADDR_WIDTH-1:0] img_ra_s;
   logic [KA_W-1:0]           kern_ra_s;
   logic [RSLT_ADDR_WIDTH-1:0] eng_wa_s, rs_wa_s;
   logic [31:0]               rs_wd_s;
   logic                      rs_we_s;

   // ---------------------------------------------------------------- bus decode
   assign bus_req_s = wbs_stb_i & wbs_cyc_i & ~ack_q;
   // A write lands on the ack cycle, while the master still holds the request.
   assign bus_wr_s  = ack_q & wbs_stb_i & wbs_cyc_i & wbs_we_i & (wbs_sel_i == 4'hF);
   assign hi_zero_s = (wbs_adr_i[31:10] == 22'd0);
   assign region_s  = wbs_adr_i[9:8];
   assign index_s   = wbs_adr_i[7:0];

   assign reg_hit_s  = hi_zero_s & (region_s == REGION_REG);
   assign img_hit_s  = hi_zero_s & (region_s == REGION_IMG)  & (32'(index_s) < 32'(IMG_DEPTH));
   assign kern_hit_s = hi_zero_s & (region_s == REGION_KERN) & (32'(index_s) < 32'(KERN_DEPTH));
   assign rslt_hit_s = hi_zero_s & (region_s == REGION_RSLT) & (32'(index_s) < 32'(RSLT_DEPTH));

   assign busy_s       = (state_q == ST_RUN) | (state_q == ST_DRAIN) | (state_q == ST_WR);
   assign start_s      = bus_wr_s & reg_hit_s & (index_s == REG_CTRL) & wbs_dat_i[CTRL_START_BIT] & ~busy_s;
   assign cfg1_we_s    = bus_wr_s & reg_hit_s & (index_s == REG_CFG) & ~busy_s;
   assign cfg2_we_s    = bus_wr_s & reg_hit_s & (index_s == REG_OUT) & ~busy_s;
   assign img_we_s     = bus_wr_s & img_hit_s  & ~busy_s;
   assign kern_we_s    = bus_wr_s & kern_hit_s & ~busy_s;
   assign host_rs_we_s = bus_wr_s & rslt_hit_s & ~busy_s;

`ifdef REN_CONV_MAX_POOL_EN
   assign pool_en_s = pool_en_q;
`else
   assign pool_en_s = 1'b0;
`endif

   // Register read images assembled from the field positions.
   always_comb begin
      ctrl_rd_s = 32'd0;
      cfg1_rd_s = 32'd0;
      cfg2_rd_s = 32'd0;
      ctrl_rd_s[CTRL_DONE_BIT] = done_q;
      ctrl_rd_s[CTRL_BUSY_BIT] = busy_s;
      cfg1_rd_s[CFG_KCOLS_LSB  +: KERN_COL_WIDTH] = kern_cols_q;
      cfg1_rd_s[CFG_COLS_LSB   +: COL_WIDTH]      = cols_q;
      cfg1_rd_s[CFG_KERNS_LSB  +: KERN_CNT_WIDTH] = kerns_q;
      cfg1_rd_s[CFG_STRIDE_LSB +: 8]              = stride_q;
      cfg2_rd_s[OUT_RCOLS_LSB  +: 8]              = rcols_q;
      cfg2_rd_s[OUT_SHIFT_LSB  +: 4]              = shift_q;
      cfg2_rd_s[OUT_MODE_BIT]                     = mode_q;
      cfg2_rd_s[OUT_POOL_BIT]                     = pool_en_s;
      cfg2_rd_s[OUT_MASK_LSB   +: LANES]          = mask_q;
   end

   // Read-data mux; anything unmapped reads as zero.
   always_comb begin
      rd_data_s = 32'd0;
      if (reg_hit_s) begin
         case (index_s)
            REG_CTRL: rd_data_s = ctrl_rd_s;
            REG_CFG:  rd_data_s = cfg1_rd_s;
            REG_OUT:  rd_data_s = cfg2_rd_s;
            default:  rd_data_s = 32'd0;
         endcase
      end else if (img_hit_s) begin
         rd_data_s = img_mem[index_s[IMG_ADDR_WIDTH-1:0]];
      end else if (kern_hit_s) begin
         rd_data_s = kern_mem[index_s[KA_W-1:0]];
      end else if (rslt_hit_s) begin
         rd_data_s = rslt_mem[index_s[RSLT_ADDR_WIDTH-1:0]];
      end else begin
         rd_data_s = 32'd0;
      end
   end

   // Bus handshake: single-cycle ack, read data registered alongside it.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         ack_q   <= 1'b0;
         dat_o_q <= 32'd0;
      end else begin
         ack_q   <= bus_req_s;
         dat_o_q <= (bus_req_s & ~wbs_we_i) ? rd_data_s : 32'd0;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_o_q;

   // Configuration registers: host writes are frozen while a run is active.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         kern_cols_q <= '0;
         cols_q      <= '0;
         kerns_q     <= '0;
         stride_q    <= 8'd0;
         rcols_q     <= 8'd0;
         shift_q     <= 4'd0;
         mode_q      <= 1'b0;
         mask_q      <= '0;
`ifdef REN_CONV_MAX_POOL_EN
         pool_en_q   <= 1'b0;
`endif
      end else begin
         if (cfg1_we_s) begin
            kern_cols_q <= wbs_dat_i[CFG_KCOLS_LSB  +: KERN_COL_WIDTH];
            cols_q      <= wbs_dat_i[CFG_COLS_LSB   +: COL_WIDTH];
            kerns_q     <= wbs_dat_i[CFG_KERNS_LSB  +: KERN_CNT_WIDTH];
            stride_q    <= wbs_dat_i[CFG_STRIDE_LSB +: 8];
         end
         if (cfg2_we_s) begin
            rcols_q   <= wbs_dat_i[OUT_RCOLS_LSB +: 8];
            shift_q   <= wbs_dat_i[OUT_SHIFT_LSB +: 4];
            mode_q    <= wbs_dat_i[OUT_MODE_BIT];
            mask_q    <= wbs_dat_i[OUT_MASK_LSB +: LANES];
`ifdef REN_CONV_MAX_POOL_EN
            pool_en_q <= wbs_dat_i[OUT_POOL_BIT];
`endif
         end
      end
   end

   // ---------------------------------------------------------------- memories
   // Image and kernel RAMs are loaded by the host only.
   always_ff @(posedge wb_clk_i) begin
      if (img_we_s) begin
         img_mem[index_s[IMG_ADDR_WIDTH-1:0]] <= wbs_dat_i;
      end
      if (kern_we_s) begin
         kern_mem[index_s[KA_W-1:0]] <= wbs_dat_i;
      end
   end

   // Engine read port: one-cycle synchronous read of the current column.
   always_ff @(posedge wb_clk_i) begin
      img_rd_q  <= img_mem[img_ra_s][DW-1:0];
      kern_rd_q <= kern_mem[kern_ra_s][DW-1:0];
   end

   // Result RAM write port: the engine owns it while busy, the host otherwise.
   always_comb begin
      rs_we_s = 1'b0;
      rs_wa_s = eng_wa_s;
      rs_wd_s = {24'd0, wr_val_s};
      if (eng_we_s) begin
         rs_we_s = 1'b1;
      end else if (host_rs_we_s) begin
         rs_we_s = 1'b1;
         rs_wa_s = index_s[RSLT_ADDR_WIDTH-1:0];
         rs_wd_s = wbs_dat_i;
      end else begin
         rs_we_s = 1'b0;
      end
   end

   // Result RAM storage.
   always_ff @(posedge wb_clk_i) begin
      if (rs_we_s) begin
         rslt_mem[rs_wa_s] <= rs_wd_s;
      end
   end

   // ---------------------------------------------------------------- datapath
   assign stride_eff_s = (stride_q == 8'd0) ? 8'd1 : stride_q;
   assign first_ok_s   = COL_WIDTH'(kern_cols_q) <= cols_q;
   // This is the final position when the next window would overrun the row.
   assign last_pos_s   = (base_q + BASE_W'(stride_eff_s) + BASE_W'(kern_cols_q)) > BASE_W'(cols_q);
   assign img_ra_s     = IMG_ADDR_WIDTH'(base_q + BASE_W'(c_q));
   assign v_s          = sat_shift(acc_s, shift_q);
   assign eng_wa_s     = RSLT_ADDR_WIDTH'(16'(k_q) * 16'(rcols_q) + 16'(rslt_idx_s));

   // Kernel column address: packed {k,c} or densely packed k*(kern_cols+1)+c.
   always_comb begin
      if (mode_q) begin
         kern_ra_s = KA_W'(KA_W'(k_q) * (KA_W'(kern_cols_q) + KA_W'(1'b1)) + KA_W'(c_q));
      end else begin
         kern_ra_s = {k_q, c_q};
      end
   end

   ren_conv_mac u_mac (
      .clk_i  (wb_clk_i),
      .rst_ni (wb_rst_i),
      .clr_i  (mac_clr_s),
      .en_i   (rd_vld_q),
      .mask_i (mask_q),
      .img_i  (img_rd_q),
      .kern_i (kern_rd_q),
      .acc_o  (acc_s)
   );

   // Result selection: with pooling, even positions are held and paired with the next.
   always_comb begin
      wr_val_s   = v_s;
      rslt_idx_s = p_q;
      eng_we_s   = 1'b0;
`ifdef REN_CONV_MAX_POOL_EN
      if (pool_en_q) begin
         rslt_idx_s = {1'b0, p_q[POS_W-1:1]};
         if (p_q[0]) begin
            wr_val_s = (pool_v_q > v_s) ? pool_v_q : v_s;
         end else begin
            wr_val_s = v_s;
         end
         eng_we_s = (state_q == ST_WR) & (p_q[0] | last_pos_s);
      end else begin
         eng_we_s = (state_q == ST_WR);
      end
`else
      eng_we_s = (state_q == ST_WR);
`endif
   end

`ifdef REN_CONV_MAX_POOL_EN
   // Holding register for the even member of a pooling pair.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         pool_v_q <= 8'd0;
      end else if ((state_q == ST_WR) && !p_q[0]) begin
         pool_v_q <= v_s;
      end
   end
`endif

   // ---------------------------------------------------------------- sequencer
   // Next-state logic: column sweep, drain of the read pipeline, write, advance.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      k_d       = k_q;
      base_d    = base_q;
      p_d       = p_q;
      done_d    = done_q;
      mac_clr_s = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_s) begin
               done_d = 1'b0;
               c_d    = '0;
               k_d    = '0;
               base_d = '0;
               p_d    = '0;
               if (first_ok_s) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            mac_clr_s = (c_q == '0);
            if (c_q == kern_cols_q) begin
               c_d     = '0;
               state_d = ST_DRAIN;
            end else begin
               c_d     = c_q + KERN_COL_WIDTH'(1'b1);
            end
         end
         ST_DRAIN: begin
            state_d = ST_WR;
         end
         ST_WR: begin
            if (last_pos_s) begin
               base_d = '0;
               p_d    = '0;
               if (k_q == kerns_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  k_d     = k_q + KERN_CNT_WIDTH'(1'b1);
                  state_d = ST_RUN;
               end
            end else begin
               base_d  = base_q + BASE_W'(stride_eff_s);
               p_d     = p_q + POS_W'(1'b1);
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state registers; reset aborts any run.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q  <= ST_IDLE;
         c_q      <= '0;
         k_q      <= '0;
         base_q   <= '0;
         p_q      <= '0;
         done_q   <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         k_q      <= k_d;
         base_q   <= base_d;
         p_q      <= p_d;
         done_q   <= done_d;
         rd_vld_q <= (state_q == ST_RUN);
      end
   end

endmodule

// File: tb/tb_ren_conv_top.sv
// tb_ren_conv_top: directed bench for ren_conv_top with hand-computed values.
module tb_ren_conv_top;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] dat_i, adr;
   logic        ack;
   logic [31:0] dat_o;

   int n_total = 0;
   int n_fail  = 0;

   ren_conv_top dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst_n),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat_i),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
      @(posedge clk); #1;
      check("ack_rise", {31'd0, ack}, 32'd1);
      r = dat_o;
      @(posedge clk); #1;
      check("ack_fall", {31'd0, ack}, 32'd0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus(1'b1, a, d, r);
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, a, 32'd0, r);
      check(tag, r, exp);
   endtask

   task automatic run_wait(input string tag);
      logic [31:0] r;
      bit seen;
      wr(32'h000, 32'h4);
      seen = 1'b0;
      r = 32'd0;
      for (int i = 0; i < 400 && !seen; i++) begin
         bus(1'b0, 32'h000, 32'd0, r);
         if (r[0]) seen = 1'b1;
      end
      check(tag, r, 32'h1);
   endtask

   initial begin
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; dat_i = 32'd0; adr = 32'd0;
      rst_n = 1'b0;
      #1;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_dat", dat_o, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Reset values and unmapped reads
      rd_check("rst_reg0", 32'h000, 32'd0);
      rd_check("rst_reg1", 32'h001, 32'd0);
      rd_check("rst_reg2", 32'h002, 32'd0);
      wr(32'h001, 32'h01020702);
      rd_check("reg1_rb", 32'h001, 32'h01020702);
      rd_check("unmap_reg3", 32'h003, 32'd0);
      rd_check("unmap_hi", 32'h400, 32'd0);

      // Load image and all-ones kernels
      for (int i = 0; i < 32; i++) wr(32'h100 + i, i | ((i + 1) << 8) | ((i + 2) << 16));
      for (int i = 0; i < 64; i++) wr(32'h200 + i, 32'h00010101);
      rd_check("img_rb", 32'h105, 32'h00070605);

      // Run 1: 3 kernels, 6 positions, unpooled -> 9p+18
      wr(32'h002, 32'h001C000B);
      wr(32'h000, 32'h4);
      rd_check("busy", 32'h000, 32'h2);
      wr(32'h001, 32'h00000000);
      rd_check("reg1_busy_ign", 32'h001, 32'h01020702);
      wr(32'h000, 32'h4);
      begin
         logic [31:0] r;
         bit seen;
         seen = 1'b0;
         r = 32'd0;
         for (int i = 0; i < 400 && !seen; i++) begin
            bus(1'b0, 32'h000, 32'd0, r);
            if (r[0]) seen = 1'b1;
         end
         check("done1", r, 32'h1);
      end
      for (int k = 0; k < 3; k++)
         for (int p = 0; p < 6; p++)
            rd_check($sformatf("r1_k%0d_p%0d", k, p), 32'h300 + k * 11 + p, 18 + 9 * p);

      // Run 2: pooling request
      wr(32'h002, 32'h001E000B);
`ifdef REN_CONV_MAX_POOL_EN
      rd_check("reg2_pool", 32'h002, 32'h001E000B);
      run_wait("done2");
      rd_check("pool_0", 32'h300, 32'd27);
      rd_check("pool_1", 32'h301, 32'd45);
      rd_check("pool_2", 32'h302, 32'd63);
      rd_check("pool_11", 32'h30B, 32'd27);
      rd_check("pool_13", 32'h30D, 32'd63);
`else
      rd_check("reg2_pool", 32'h002, 32'h001C000B);
      run_wait("done2");
      rd_check("pool_0", 32'h300, 32'd18);
      rd_check("pool_1", 32'h301, 32'd27);
      rd_check("pool_2", 32'h302, 32'd36);
      rd_check("pool_11", 32'h30B, 32'd18);
      rd_check("pool_13", 32'h30D, 32'd36);
`endif
      rd_check("pool_3", 32'h303, 32'd45);

      // Run 3: lane 0 only, shift 1 -> (3p+3)>>1
      wr(32'h002, 32'h0004010B);
      run_wait("done3");
      rd_check("mask_0", 32'h300, 32'd1);
      rd_check("mask_1", 32'h301, 32'd3);
      rd_check("mask_5", 32'h305, 32'd9);
      rd_check("mask_11", 32'h30B, 32'd1);

      // Run 4: saturation
      for (int i = 0; i < 64; i++) wr(32'h200 + i, 32'h00FFFFFF);
      wr(32'h002, 32'h001C000B);
      run_wait("done4");
      rd_check("sat_0", 32'h300, 32'd255);
      rd_check("sat_5", 32'h305, 32'd255);
      rd_check("sat_16", 32'h310, 32'd255);
      rd_check("sat_27", 32'h31B, 32'd255);

      // Run 5: mode1 kernel addressing, stride 2, 2 kernels
      for (int i = 0; i < 3; i++) wr(32'h200 + i, 32'h00010101);
      for (int i = 3; i < 6; i++) wr(32'h200 + i, 32'h00000002);
      wr(32'h001, 32'h02010702);
      wr(32'h002, 32'h001D000B);
      run_wait("done5");
      rd_check("m1_0", 32'h300, 32'd18);
      rd_check("m1_1", 32'h301, 32'd36);
      rd_check("m1_2", 32'h302, 32'd54);
      rd_check("m1_3_kept", 32'h303, 32'd255);
      rd_check("m1_11", 32'h30B, 32'd6);
      rd_check("m1_12", 32'h30C, 32'd18);
      rd_check("m1_13", 32'h30D, 32'd30);

      // Reset in the middle of a run
      wr(32'h000, 32'h4);
      rd_check("busy_mid", 32'h000, 32'h2);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("midrst_ack", {31'd0, ack}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      rd_check("midrst_reg0", 32'h000, 32'd0);
      rd_check("midrst_reg1", 32'h001, 32'd0);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
